// File: rtl/seg7_pkg.sv
// seg7_pkg: shared active-high 7-segment patterns and digit-code width
package seg7_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to active-high {a..g} pattern, hex letters optional
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  input  logic               hex_mode,
  output logic [6:0]         pat
);
  // table lookup; codes above 9 show letters only in hex mode
  always_comb begin
    pat = SEG_BLANK;
    case (code)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = hex_mode ? SEG_A : SEG_BLANK;
      4'hB: pat = hex_mode ? SEG_B : SEG_BLANK;
      4'hC: pat = hex_mode ? SEG_C : SEG_BLANK;
      4'hD: pat = hex_mode ? SEG_D : SEG_BLANK;
      4'hE: pat = hex_mode ? SEG_E : SEG_BLANK;
      4'hF: pat = hex_mode ? SEG_F : SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed N-digit 7-segment scanner with frame-coherent capture
module seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD          = 16,
  parameter bit HEX_MODE       = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic                          blink_tick,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          frame_done
);
  localparam int CW = $clog2(REFRESH_DIV + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = DIGIT_W * NUM_DIGITS;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  blink_phase;
  logic [DW-1:0]         shd;
  logic [NUM_DIGITS-1:0] shd_dp;
  logic                  slot_end;
  logic                  frame_end;
  logic                  hide;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] lead;
  logic [DIGIT_W-1:0]    code;
  logic [6:0]            pat;
  logic [6:0]            seg_on;
  logic                  dp_on;
  logic [NUM_DIGITS-1:0] an_on;

  assign slot_end  = cnt == CW'(REFRESH_DIV - 1);
  assign frame_end = slot_end && idx == IW'(NUM_DIGITS - 1);
  assign code      = DIGIT_W'(shd >> (DIGIT_W * idx));
  assign hide      = blink_phase && blink_mask[idx];

  seg7_hex_decode u_dec (
    .code     (code),
    .hex_mode (HEX_MODE),
    .pat      (pat)
  );

  // a digit is a leading zero when it and every more-significant digit are zero; digit 0 always shows
  always_comb begin
    lead     = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (shd[DIGIT_W*i +: DIGIT_W] == '0);
      lead[i]  = BLANK_LEADING && zero_run;
    end
  end

  // active-high view of the next output word; blanked digits keep their dp, blink kills both
  always_comb begin
    seg_on = (!enable || hide || lead[idx]) ? SEG_BLANK : pat;
    dp_on  = enable && !hide && shd_dp[idx];
    an_on  = (enable && cnt >= CW'(GUARD)) ? NUM_DIGITS'(1) << idx : '0;
  end

  // slot/digit counters, blink phase and shadow capture (every cycle while disabled)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      blink_phase <= 1'b0;
      shd         <= '0;
      shd_dp      <= '0;
    end else begin
      blink_phase <= blink_phase ^ blink_tick;
      cnt         <= (!enable || slot_end) ? '0 : cnt + 1'b1;
      idx         <= !enable ? '0 : !slot_end ? idx : (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      if (!enable || frame_end) begin
        shd    <= digits_in;
        shd_dp <= dp_in;
      end
    end
  end

  // output registers; polarity inversion lives only here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= {7{SEG_ACTIVE_LOW}};
      dp         <= SEG_ACTIVE_LOW;
      an         <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_on ^ {7{SEG_ACTIVE_LOW}};
      dp         <= dp_on ^ SEG_ACTIVE_LOW;
      an         <= an_on ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
      frame_done <= enable && frame_end;
    end
  end
endmodule
